// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/DIV/REM engine: one result bit per clock, WIDTH iterations per operation.
// Shift-add multiply (LSB-first) and restoring divide (MSB-first) share one IDLE/RUN/DONE FSM.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_MUL = 5'b01100;
  localparam logic [4:0] OP_DIV = 5'b10010;
  localparam logic [4:0] OP_REM = 5'b10100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]      cnt;
  logic [4:0]         op_r;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               accept;
  logic               legal;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;

  assign legal = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_REM);

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = legal ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_n = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = legal ? S_RUN : S_DONE;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    mul_sum = acc + (b_r[0] ? a_sh : '0);
  end

  // Restoring divide step; a trial difference that fits in WIDTH bits means no restore.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_r};
    div_ok    = (div_diff[WIDTH+1:WIDTH] == 2'b00);
    rem_n     = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_n     = {quo[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      op_r <= '0;
      a_sh <= '0;
      b_r  <= '0;
      acc  <= '0;
      rem  <= '0;
      quo  <= '0;
      y    <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_r <= opcode;
      a_sh <= {{WIDTH{1'b0}}, a};
      b_r  <= b;
      acc  <= '0;
      rem  <= '0;
      quo  <= a;
      if (!legal) begin
        y   <= '0;
        err <= 1'b1;
      end
    end else if (state == S_RUN) begin
      cnt <= cnt + 1'b1;
      if (op_r == OP_MUL) begin
        acc  <= mul_sum;
        a_sh <= a_sh << 1;
        b_r  <= b_r >> 1;
      end else begin
        rem <= rem_n;
        quo <= quo_n;
      end
      // Final iteration: publish the just-computed step directly so y lands on the DONE edge.
      if (cnt == LAST) begin
        err <= 1'b0;
        if (op_r == OP_MUL) begin
          y <= mul_sum[WIDTH-1:0];
        end else if (op_r == OP_DIV) begin
          y <= quo_n;
        end else begin
          y <= rem_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: hand-computed results, latency, busy width and reset abort.
module tb_alu_muldiv_seq;

  localparam int unsigned WIDTH = 64;
  localparam logic [4:0] OP_MUL = 5'b01100;
  localparam logic [4:0] OP_DIV = 5'b10010;
  localparam logic [4:0] OP_REM = 5'b10100;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [4:0]       opcode = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             err;

  int checks = 0;
  int failures = 0;

  alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .y      (y),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one operation (back-to-back when called while done is high), scrambles the inputs
  // during the run and optionally pulses start mid-RUN, then checks latency, busy width, y, err.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [63:0] aa,
                       input logic [63:0] bb, input logic [63:0] ey, input logic ee,
                       input int lat, input bit poke);
    int n;
    int nbusy;
    n = 0;
    nbusy = 0;
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    a      = aa;
    b      = bb;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = ~aa;
    b      = ~bb;
    opcode = OP_MUL;
    if (busy) nbusy++;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) nbusy++;
      if (poke && n == 20) begin
        start  = 1'b1;
        opcode = OP_REM;
        a      = 64'd3;
        b      = 64'd2;
      end
      if (poke && n == 21) start = 1'b0;
    end
    check_eq($sformatf("%s.latency", tag), 64'(n), 64'(lat));
    check_eq($sformatf("%s.busy_cycles", tag), 64'(nbusy), 64'(lat));
    check_eq($sformatf("%s.y", tag), y, ey);
    check_eq($sformatf("%s.err", tag), {63'd0, err}, {63'd0, ee});
  endtask

  initial begin
    int seen;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.busy", {63'd0, busy}, 64'd0);
    check_eq("reset.done", {63'd0, done}, 64'd0);
    check_eq("reset.y", y, 64'd0);
    check_eq("reset.err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("mul_7x6", OP_MUL, 64'd7, 64'd6, 64'd42, 1'b0, 64, 1'b0);
    // Next issue happens in the DONE cycle; done must drop right after the accept edge.
    do_op("mul_2p63x2", OP_MUL, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b0, 64, 1'b0);
    do_op("mul_ones", OP_MUL, '1, '1, 64'd1, 1'b0, 64, 1'b0);
    do_op("mul_wide", OP_MUL, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 1'b0, 64, 1'b0);
    do_op("div_100_7", OP_DIV, 64'd100, 64'd7, 64'd14, 1'b0, 64, 1'b1);
    do_op("rem_100_7", OP_REM, 64'd100, 64'd7, 64'd2, 1'b0, 64, 1'b0);
    do_op("div_5_9", OP_DIV, 64'd5, 64'd9, 64'd0, 1'b0, 64, 1'b0);
    do_op("rem_5_9", OP_REM, 64'd5, 64'd9, 64'd5, 1'b0, 64, 1'b0);
    do_op("div_max_3", OP_DIV, '1, 64'd3, 64'h5555_5555_5555_5555, 1'b0, 64, 1'b0);
    do_op("rem_max_10", OP_REM, '1, 64'd10, 64'd5, 1'b0, 64, 1'b0);
    do_op("div_by0", OP_DIV, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 1'b0);
    do_op("rem_by0", OP_REM, 64'd123, 64'd0, 64'd123, 1'b0, 64, 1'b0);
    do_op("illegal", 5'b00000, 64'd9, 64'd9, 64'd0, 1'b1, 0, 1'b0);
    do_op("mul_after_illegal", OP_MUL, 64'd3, 64'd5, 64'd15, 1'b0, 64, 1'b0);

    // Abort a divide 30 cycles in; y holds 15 beforehand, so y==0 proves the clear.
    repeat (2) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    opcode = OP_DIV;
    a      = 64'd1000;
    b      = 64'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort.busy", {63'd0, busy}, 64'd0);
    check_eq("abort.done", {63'd0, done}, 64'd0);
    check_eq("abort.y", y, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check_eq("abort.no_done", 64'(seen), 64'd0);
    do_op("div_after_abort", OP_DIV, 64'd1000, 64'd3, 64'd333, 1'b0, 64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
